// File: rtl/mult_seq_hs.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are handled as magnitudes plus a result sign applied on the last step.
module mult_seq_hs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic [WIDTH-1:0]   s,
    output logic               ovf,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] acc_sh_c;
    logic [WIDTH-1:0] mplier_sh_c;
    logic [PW-1:0]    mag_c;
    logic [PW-1:0]    prod_c;
    logic             ovf_c;
    logic             last_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;

    // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1) for the most-negative value.
    always_comb begin
        a_mag_c = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag_c = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    // One add-and-shift step; low product bits shift into the multiplier register.
    always_comb begin
        sum_c       = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_sh_c    = sum_c[WIDTH:1];
        mplier_sh_c = {sum_c[0], mplier_q[WIDTH-1:1]};
        mag_c       = {acc_sh_c, mplier_sh_c};
        prod_c      = neg_q ? (~mag_c + PW'(1)) : mag_c;
        if (sgn_q) begin
            ovf_c = !((&prod_c[PW-1:WIDTH-1]) || !(|prod_c[PW-1:WIDTH-1]));
        end else begin
            ovf_c = |prod_c[PW-1:WIDTH];
        end
        last_c = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it cycle-exactly.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        p_d      = p_q;
        s_d      = s_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a_mag_c;
                    mplier_d = b_mag_c;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sgn_d    = is_signed;
                    neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            CALC: begin
                acc_d    = acc_sh_c;
                mplier_d = mplier_sh_c;
                cnt_d    = last_c ? '0 : cnt_q + CW'(1);
                if (last_c) begin
                    p_d   = prod_c;
                    s_d   = prod_c[WIDTH-1:0];
                    ovf_d = ovf_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            sgn_q       <= 1'b0;
            p_q         <= '0;
            s_q         <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            sgn_q       <= sgn_d;
            p_q         <= p_d;
            s_q         <= s_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;
    assign s         = s_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_seq_hs.sv
// Bench for mult_seq_hs at WIDTH 8, 2 and 16 against an integer-arithmetic reference model.
module tb_mult_seq_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_bus, b_bus;
    logic        sgn_bus, out_ready_bus;
    logic        iv8, iv2, iv16;
    int          cur;

    logic        ir8, ov8, ovf8, busy8;
    logic [15:0] p8;
    logic [7:0]  s8;
    logic        ir2, ov2, ovf2, busy2;
    logic [3:0]  p2;
    logic [1:0]  s2;
    logic        ir16, ov16, ovf16, busy16;
    logic [31:0] p16;
    logic [15:0] s16;

    logic        ir_obs, ov_obs, ovf_obs, busy_obs;
    logic [31:0] p_obs;
    logic [15:0] s_obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_seq_hs #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .is_signed(sgn_bus),
        .out_valid(ov8), .out_ready(out_ready_bus),
        .p(p8), .s(s8), .ovf(ovf8), .busy(busy8)
    );

    mult_seq_hs #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(a_bus[1:0]), .b(b_bus[1:0]), .is_signed(sgn_bus),
        .out_valid(ov2), .out_ready(out_ready_bus),
        .p(p2), .s(s2), .ovf(ovf2), .busy(busy2)
    );

    mult_seq_hs #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a_bus), .b(b_bus), .is_signed(sgn_bus),
        .out_valid(ov16), .out_ready(out_ready_bus),
        .p(p16), .s(s16), .ovf(ovf16), .busy(busy16)
    );

    // Route the selected instance onto common observation signals.
    always_comb begin
        ir_obs = ir8; ov_obs = ov8; ovf_obs = ovf8; busy_obs = busy8;
        p_obs  = 32'(p8); s_obs = 16'(s8);
        if (cur == 1) begin
            ir_obs = ir2; ov_obs = ov2; ovf_obs = ovf2; busy_obs = busy2;
            p_obs  = 32'(p2); s_obs = 16'(s2);
        end else if (cur == 2) begin
            ir_obs = ir16; ov_obs = ov16; ovf_obs = ovf16; busy_obs = busy16;
            p_obs  = p16; s_obs = s16;
        end
    end

    function automatic int wof(input int c);
        return (c == 1) ? 2 : (c == 2) ? 16 : 8;
    endfunction

    // Reference: exact integer product, truncated views and range-based overflow.
    function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                  input bit sg, output logic [31:0] ep, output logic [15:0] es,
                                  output logic eovf);
        longint m, x, y, pr, half;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        x    = longint'(av) & m;
        y    = longint'(bv) & m;
        if (sg && x >= half) x = x - (longint'(1) << w);
        if (sg && y >= half) y = y - (longint'(1) << w);
        pr   = x * y;
        ep   = 32'(pr & ((longint'(1) << (2 * w)) - 1));
        es   = 16'(pr & m);
        if (sg) eovf = (pr < -half) || (pr > half - 1);
        else    eovf = (pr > m);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_valid(input bit v);
        iv8  = v && (cur == 0);
        iv2  = v && (cur == 1);
        iv16 = v && (cur == 2);
    endtask

    // Offer one operation and leave the bench just after the accept edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input bit sg);
        int n = 0;
        while (!ir_obs && n < 50) begin @(negedge clk); n++; end
        check("start_in_ready", 32'(ir_obs), 32'd1);
        a_bus = av; b_bus = bv; sgn_bus = sg; out_ready_bus = 1'b0;
        drive_valid(1'b1);
        @(negedge clk);
        drive_valid(1'b0);
        a_bus = 16'($urandom); b_bus = 16'($urandom); sgn_bus = ~sg;
        check("accept_busy", 32'(busy_obs), 32'd1);
        check("accept_in_ready_low", 32'(ir_obs), 32'd0);
    endtask

    // Edges counted from the accept edge inclusive until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (!ov_obs && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input bit sg, input int hold,
                         output logic [31:0] gp, output logic [15:0] gs, output logic govf);
        int w = wof(cur);
        int n;
        logic [31:0] ep; logic [15:0] es; logic eovf;
        model(w, av, bv, sg, ep, es, eovf);
        start_op(av, bv, sg);
        wait_valid(n);
        check("latency", 32'(n), 32'(w + 1));
        check("p", p_obs, ep);
        check("s", 32'(s_obs), 32'(es));
        check("ovf", 32'(ovf_obs), 32'(eovf));
        gp = p_obs; gs = s_obs; govf = ovf_obs;
        repeat (hold) @(negedge clk);
        out_ready_bus = 1'b1;
        @(negedge clk);
        out_ready_bus = 1'b0;
        check("release_in_ready", 32'(ir_obs), 32'd1);
        check("release_out_valid", 32'(ov_obs), 32'd0);
    endtask

    typedef struct {
        logic [31:0] p;
        logic [15:0] s;
        logic        ovf;
    } res_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] gp, hp; logic [15:0] gs, hs; logic govf, hovf;
        int n;
        res_t q[$];
        res_t e;
        logic [15:0] ta[100], tbv[100];
        bit          ts[100];
        int k, ntaken, last_acc, cyc;
        bit acc;

        cur = 0; rst = 1'b1; a_bus = '0; b_bus = '0; sgn_bus = 1'b0; out_ready_bus = 1'b0;
        drive_valid(1'b0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(ov_obs), 32'd0);
        check("rst_busy", 32'(busy_obs), 32'd0);
        check("rst_p", p_obs, 32'd0);
        check("rst_s", 32'(s_obs), 32'd0);
        check("rst_ovf", 32'(ovf_obs), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(ir_obs), 32'd1);

        // Directed WIDTH=8 points with hand-computed results.
        do_op(16'd15, 16'd17, 1'b0, 0, gp, gs, govf);
        check("d15x17_p", gp, 32'h00FF); check("d15x17_s", 32'(gs), 32'hFF); check("d15x17_ovf", 32'(govf), 32'd0);
        do_op(16'hFF, 16'hFF, 1'b0, 2, gp, gs, govf);
        check("dFFxFF_p", gp, 32'hFE01); check("dFFxFF_s", 32'(gs), 32'h01); check("dFFxFF_ovf", 32'(govf), 32'd1);
        do_op(16'h80, 16'h80, 1'b1, 0, gp, gs, govf);
        check("dm128sq_p", gp, 32'h4000); check("dm128sq_s", 32'(gs), 32'h00); check("dm128sq_ovf", 32'(govf), 32'd1);
        do_op(16'h80, 16'h01, 1'b1, 1, gp, gs, govf);
        check("dm128x1_p", gp, 32'hFF80); check("dm128x1_s", 32'(gs), 32'h80); check("dm128x1_ovf", 32'(govf), 32'd0);
        do_op(16'h00, 16'hA5, 1'b1, 0, gp, gs, govf);
        check("dzero_p", gp, 32'd0); check("dzero_ovf", 32'(govf), 32'd0);

        // Backpressure: result must stay put and further offers must be refused.
        start_op(16'hFF, 16'hFF, 1'b0);
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd9);
        hp = p_obs; hs = s_obs; hovf = ovf_obs;
        for (int i = 0; i < 20; i++) begin
            a_bus = 16'($urandom); b_bus = 16'($urandom); sgn_bus = 1'($urandom);
            drive_valid(1'($urandom));
            @(negedge clk);
            check("bp_in_ready", 32'(ir_obs), 32'd0);
            check("bp_out_valid", 32'(ov_obs), 32'd1);
            check("bp_p", p_obs, 32'hFE01);
        end
        check("bp_s", 32'(s_obs), 32'(hs));
        check("bp_ovf", 32'(ovf_obs), 32'(hovf));
        drive_valid(1'b0);
        out_ready_bus = 1'b1;
        @(negedge clk);
        out_ready_bus = 1'b0;
        check("bp_release_in_ready", 32'(ir_obs), 32'd1);
        @(negedge clk);
        check("bp_no_accept", 32'(busy_obs), 32'd0);
        check("bp_idle_keeps_p", p_obs, hp);

        // Reset during the 4th CALC cycle discards the operation.
        start_op(16'd7, 16'd9, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(ov_obs), 32'd0);
        check("mid_rst_p", p_obs, 32'd0);
        check("mid_rst_in_ready", 32'(ir_obs), 32'd1);
        check("mid_rst_busy", 32'(busy_obs), 32'd0);
        rst = 1'b0;
        do_op(16'hFFFD, 16'd5, 1'b1, 0, gp, gs, govf);
        check("m3x5_p", gp, 32'hFFF1);

        // Back-to-back with in_valid held and random consumer stalls.
        for (int i = 0; i < 100; i++) begin
            ta[i] = 16'($urandom); tbv[i] = 16'($urandom); ts[i] = 1'($urandom);
        end
        k = 0; ntaken = 0; last_acc = -1; cyc = 0;
        a_bus = ta[0]; b_bus = tbv[0]; sgn_bus = ts[0];
        drive_valid(1'b1);
        while ((k < 100 || q.size() > 0) && cyc < 5000) begin
            out_ready_bus = 1'($urandom);
            if (ov_obs && out_ready_bus) begin
                if (q.size() == 0) begin
                    check("b2b_extra_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("b2b_p", p_obs, e.p);
                    check("b2b_s", 32'(s_obs), 32'(e.s));
                    check("b2b_ovf", 32'(ovf_obs), 32'(e.ovf));
                end
                ntaken++;
            end
            acc = ir_obs && (k < 100);
            if (acc) begin
                if (last_acc >= 0) check("b2b_interval", 32'((cyc - last_acc) >= 10), 32'd1);
                last_acc = cyc;
                model(8, ta[k], tbv[k], ts[k], e.p, e.s, e.ovf);
                q.push_back(e);
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                k++;
                if (k < 100) begin
                    a_bus = ta[k]; b_bus = tbv[k]; sgn_bus = ts[k];
                end else begin
                    drive_valid(1'b0);
                end
            end
        end
        out_ready_bus = 1'b0;
        drive_valid(1'b0);
        check("b2b_accepts", 32'(k), 32'd100);
        check("b2b_results", 32'(ntaken), 32'd100);
        check("b2b_queue_empty", 32'(q.size()), 32'd0);

        // WIDTH=2 exhaustive in both modes.
        cur = 1;
        @(negedge clk);
        for (int sg = 0; sg < 2; sg++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    do_op(16'(x), 16'(y), 1'(sg), 0, gp, gs, govf);

        // WIDTH=16 corner and random operands.
        cur = 2;
        @(negedge clk);
        do_op(16'h8000, 16'h8000, 1'b1, 0, gp, gs, govf);
        check("w16_m_sq_p", gp, 32'h40000000);
        check("w16_m_sq_ovf", 32'(govf), 32'd1);
        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), gp, gs, govf);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
